// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: word geometry, port ids and the
// address legality rule used on the granted request.
package dmem_pkg;

  localparam int WORD_BYTES    = 4;
  localparam int DEPTH_DEFAULT = 32;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Word aligned and inside the memory; the address is widened so any AW fits.
  function automatic logic addr_legal(input logic [63:0] addr, input int depth);
    return ((addr % 64'(WORD_BYTES)) == 64'd0) &&
           ((addr / 64'(WORD_BYTES)) < 64'(depth));
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, contention goes to the
// port that did not win the most recent grant.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt[PORT_A] = req[PORT_A] & (~req[PORT_B] | (last == PORT_B));
    gnt[PORT_B] = req[PORT_B] & (~req[PORT_A] | (last == PORT_A));
  end

  // Starting from B means A wins the first contention after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= PORT_B;
    end else if (|gnt) begin
      last <= gnt[PORT_B] ? PORT_B : PORT_A;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (port A) and the debug/DMA
// loader (port B): one bounds-checked access per cycle, one-cycle registered responses.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          a_err,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          b_err,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          granted;
  logic          sel_we;
  logic          sel_legal;
  logic          access;
  logic          rd_ok;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Requests are masked during reset so no grant or memory strobe leaks out.
  assign req = {b_req, a_req} & {2{~rst}};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign a_gnt   = gnt[PORT_A];
  assign b_gnt   = gnt[PORT_B];
  assign granted = |gnt;

  always_comb begin
    sel_we    = gnt[PORT_B] ? b_we    : a_we;
    sel_addr  = gnt[PORT_B] ? b_addr  : a_addr;
    sel_wdata = gnt[PORT_B] ? b_wdata : a_wdata;
  end

  assign sel_legal = addr_legal(64'(sel_addr), DEPTH);
  assign access    = granted & sel_legal;
  assign rd_ok     = sel_legal & ~sel_we;

  // An illegal request is still granted so the requester can release, but the
  // memory sees an idle cycle.
  assign mem_read  = access & ~sel_we;
  assign mem_write = access & sel_we;
  assign mem_addr  = access ? sel_addr  : '0;
  assign mem_wdata = access ? sel_wdata : '0;

  logic          a_vld_p1;
  logic          a_err_p1;
  logic [DW-1:0] a_rdata_p1;
  logic          b_vld_p1;
  logic          b_err_p1;
  logic [DW-1:0] b_rdata_p1;

  // Grant edge -> response stage: capture the asynchronous read data for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld_p1   <= 1'b0;
      a_err_p1   <= 1'b0;
      a_rdata_p1 <= '0;
      b_vld_p1   <= 1'b0;
      b_err_p1   <= 1'b0;
      b_rdata_p1 <= '0;
    end else begin
      a_vld_p1   <= gnt[PORT_A] & rd_ok;
      a_err_p1   <= gnt[PORT_A] & ~sel_legal;
      a_rdata_p1 <= (gnt[PORT_A] & rd_ok) ? mem_rdata : '0;
      b_vld_p1   <= gnt[PORT_B] & rd_ok;
      b_err_p1   <= gnt[PORT_B] & ~sel_legal;
      b_rdata_p1 <= (gnt[PORT_B] & rd_ok) ? mem_rdata : '0;
    end
  end

  assign a_rvalid = a_vld_p1;
  assign a_err    = a_err_p1;
  assign a_rdata  = a_rdata_p1;
  assign b_rvalid = b_vld_p1;
  assign b_err    = b_err_p1;
  assign b_rdata  = b_rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic from two requesters,
// checked against a transaction-level model of the shared memory.
module tb_dmem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, a_gnt, a_rvalid, a_err;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_rvalid, b_err;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical memory attached to the DUT: asynchronous read, write at the clock edge.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_write && mem_addr < 32'(DEPTH * 4)) begin
      mem[mem_addr[6:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_read && mem_addr < 32'(DEPTH * 4)) ? mem[mem_addr[6:2]] : '0;

  typedef struct {
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        tr [2];
  logic [31:0] ref_mem [DEPTH];
  bit          prev_b;
  bit          exp_rv [2];
  bit          exp_err [2];
  logic [31:0] exp_rd [2];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          obs_a_gnt, obs_b_gnt, obs_mr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ok_addr(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < DEPTH);
  endfunction

  task automatic drive();
    a_req = tr[0].req; a_we = tr[0].we; a_addr = tr[0].addr; a_wdata = tr[0].wdata;
    b_req = tr[1].req; b_we = tr[1].we; b_addr = tr[1].addr; b_wdata = tr[1].wdata;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".a_gnt"}, a_gnt, 0);
    check({tag, ".b_gnt"}, b_gnt, 0);
    check({tag, ".a_rvalid"}, a_rvalid, 0);
    check({tag, ".b_rvalid"}, b_rvalid, 0);
    check({tag, ".a_rdata"}, a_rdata, 0);
    check({tag, ".b_rdata"}, b_rdata, 0);
    check({tag, ".a_err"}, a_err, 0);
    check({tag, ".b_err"}, b_err, 0);
    check({tag, ".mem_read"}, mem_read, 0);
    check({tag, ".mem_write"}, mem_write, 0);
    check({tag, ".mem_addr"}, mem_addr, 0);
    check({tag, ".mem_wdata"}, mem_wdata, 0);
  endtask

  // Held for two edges; the model forgets responses and memory contents.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    prev_b = 1'b1;
    exp_rv = '{0, 0};
    exp_err = '{0, 0};
    exp_rd = '{0, 0};
    #1 check_zero(tag);
    @(posedge clk);
    #1 check_zero(tag);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock cycle: drive requests, check mid-cycle, then retire the winner.
  task automatic step(input string tag);
    int          w;
    bit          lg;
    bit          nrv [2];
    bit          nerr [2];
    logic [31:0] nrd [2];
    logic [31:0] e_addr, e_wdata;
    bit          e_mr, e_mw;
    drive();
    #4;
    w = -1;
    if (tr[0].req && tr[1].req) w = prev_b ? 0 : 1;
    else if (tr[0].req) w = 0;
    else if (tr[1].req) w = 1;
    lg = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_addr = '0; e_wdata = '0;
    if (w >= 0) begin
      lg = ok_addr(tr[w].addr);
      e_mr = lg && !tr[w].we;
      e_mw = lg && tr[w].we;
      e_addr = tr[w].addr;
      e_wdata = tr[w].wdata;
    end
    obs_a_gnt = a_gnt; obs_b_gnt = b_gnt; obs_mr = mem_read;
    check({tag, ".a_gnt"}, a_gnt, w == 0);
    check({tag, ".b_gnt"}, b_gnt, w == 1);
    check({tag, ".mem_read"}, mem_read, e_mr);
    check({tag, ".mem_write"}, mem_write, e_mw);
    if (w < 0 || lg) begin
      check({tag, ".mem_addr"}, mem_addr, e_addr);
      check({tag, ".mem_wdata"}, mem_wdata, e_wdata);
    end
    check({tag, ".a_rvalid"}, a_rvalid, exp_rv[0]);
    check({tag, ".a_rdata"}, a_rdata, exp_rv[0] ? exp_rd[0] : 32'h0);
    check({tag, ".a_err"}, a_err, exp_err[0]);
    check({tag, ".b_rvalid"}, b_rvalid, exp_rv[1]);
    check({tag, ".b_rdata"}, b_rdata, exp_rv[1] ? exp_rd[1] : 32'h0);
    check({tag, ".b_err"}, b_err, exp_err[1]);
    @(posedge clk);
    nrv = '{0, 0}; nerr = '{0, 0}; nrd = '{0, 0};
    if (w >= 0) begin
      prev_b = (w == 1);
      if (!lg) nerr[w] = 1'b1;
      else if (tr[w].we) ref_mem[tr[w].addr / 4] = tr[w].wdata;
      else begin
        nrv[w] = 1'b1;
        nrd[w] = ref_mem[tr[w].addr / 4];
      end
      tr[w].req = 1'b0;
    end
    exp_rv = nrv; exp_err = nerr; exp_rd = nrd;
    #1;
  endtask

  initial begin
    tr[0] = '{1'b1, 1'b0, 32'h10, 32'h0};
    tr[1] = '{1'b0, 1'b0, 32'h0, 32'h0};
    do_reset("t1_rst");
    step("t1");
    check("t1_first_a_gnt", obs_a_gnt, 1);

    tr[0].req = 1'b0;
    do_reset("t3_rst");
    for (int i = 0; i < 6; i++) begin
      if (!tr[0].req) tr[0] = '{1'b1, 1'b0, 32'h4, 32'h0};
      if (!tr[1].req) tr[1] = '{1'b1, 1'b0, 32'h8, 32'h0};
      step("t3");
      check("t3_alt_b_gnt", obs_b_gnt, 64'(i % 2));
    end
    tr[0].req = 1'b0;
    tr[1].req = 1'b0;

    tr[0] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF};
    step("t2_wr");
    tr[0] = '{1'b1, 1'b0, 32'h10, 32'h0};
    step("t2_rd");
    check("t2_rvalid", a_rvalid, 1);
    check("t2_rdata", a_rdata, 32'hDEADBEEF);

    tr[1] = '{1'b1, 1'b0, 32'h6, 32'h0};
    step("t4_mis");
    check("t4_mis_gnt", obs_b_gnt, 1);
    check("t4_mis_mr", obs_mr, 0);
    check("t4_mis_err", b_err, 1);
    check("t4_mis_rv", b_rvalid, 0);
    tr[1] = '{1'b1, 1'b0, 32'h80, 32'h0};
    step("t4_oob");
    check("t4_oob_gnt", obs_b_gnt, 1);
    check("t4_oob_mr", obs_mr, 0);
    check("t4_oob_err", b_err, 1);
    check("t4_oob_rv", b_rvalid, 0);
    tr[1] = '{1'b1, 1'b0, 32'h10, 32'h0};
    step("t4_rb");
    check("t4_unchanged", b_rdata, 32'hDEADBEEF);

    tr[0] = '{1'b1, 1'b1, 32'h20, 32'h1};
    tr[1] = '{1'b1, 1'b1, 32'h20, 32'h2};
    step("t5_a");
    check("t5_a_first", obs_a_gnt, 1);
    step("t5_b");
    check("t5_b_second", obs_b_gnt, 1);
    tr[0] = '{1'b1, 1'b0, 32'h20, 32'h0};
    step("t5_rd");
    check("t5_rdata", a_rdata, 32'h2);

    tr[0] = '{1'b1, 1'b0, 32'h10, 32'h0};
    step("t6_rd");
    check("t6_rvalid_before", a_rvalid, 1);
    tr[0] = '{1'b1, 1'b0, 32'h10, 32'h0};
    do_reset("t6_rst");
    tr[1] = '{1'b1, 1'b0, 32'h14, 32'h0};
    step("t6_after");
    check("t6_a_priority", obs_a_gnt, 1);
    step("t6_b");
    check("t6_mem_cleared", a_rdata, 32'h0);

    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!tr[p].req && $urandom_range(0, 3) != 0) begin
          tr[p].req = 1'b1;
          tr[p].we = 1'($urandom_range(0, 1));
          tr[p].wdata = $urandom;
          case ($urandom_range(0, 9))
            0: tr[p].addr = 32'(4 * $urandom_range(0, 7) + $urandom_range(1, 3));
            1: tr[p].addr = 32'(4 * $urandom_range(DEPTH, DEPTH + 64));
            2: tr[p].addr = 32'(4 * $urandom_range(0, DEPTH - 1));
            default: tr[p].addr = 32'(4 * $urandom_range(0, 7));
          endcase
        end
      end
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
